// File: rtl/sram_controller_pkg.sv
// Shared definitions for the MEM-stage to 16-bit SRAM bridge: FSM state
// encoding, SRAM bus widths, default data-memory base and the word mapping.
package sram_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int unsigned BASE_ADDR_DEFAULT = 32'd1024;
   localparam int unsigned SRAM_ADDR_W       = 18;
   localparam int unsigned SRAM_DQ_W         = 16;
   localparam int unsigned WORD_W            = 17;

   // Byte address -> 32-bit word index inside the data memory, 17 bits wide.
   function automatic logic [WORD_W-1:0] word_index(input logic [31:0] addr,
                                                    input logic [31:0] base);
      logic [31:0] offset_s;
      offset_s = addr - base;
      return offset_s[18:2];
   endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two sequenced half-word SRAM
// accesses (low half, then high half) and holds ready low so the pipeline
// freezes until the whole word has been transferred.
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int unsigned BASE_ADDR   = BASE_ADDR_DEFAULT,
   parameter int unsigned HALF_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_UB_N,
   output logic                   SRAM_LB_N,
   output logic                   SRAM_CE_N,
   output logic                   SRAM_OE_N
);

   localparam int unsigned      CNT_W    = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_CYCLES - 1);

   state_t                   state_r;
   logic [CNT_W-1:0]         cnt_r;
   logic [WORD_W-1:0]        word_r;
   logic [31:0]              data_r;
   logic                     is_write_r;
   logic [SRAM_ADDR_W-1:0]   addr_r;
   logic                     we_n_r;
   logic                     dq_oe_r;
   logic [SRAM_DQ_W-1:0]     dq_out_r;
   logic [31:0]              read_data_r;
   logic                     req_s;
   logic                     phase_end_s;
   logic                     ready_s;
   logic [WORD_W-1:0]        req_word_s;

   assign req_s       = wr_en | rd_en;
   assign phase_end_s = (cnt_r == CNT_LAST);
   assign req_word_s  = word_index(address, 32'(BASE_ADDR));

   // Sequencer: captures the request, then steps LOW -> HIGH -> DONE with registered bus outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         word_r      <= '0;
         data_r      <= 32'h0000_0000;
         is_write_r  <= 1'b0;
         addr_r      <= '0;
         we_n_r      <= 1'b1;
         dq_oe_r     <= 1'b0;
         dq_out_r    <= 16'h0000;
         read_data_r <= 32'h0000_0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_s) begin
                  // Write wins when both enables are raised together.
                  state_r    <= ST_LOW;
                  cnt_r      <= '0;
                  word_r     <= req_word_s;
                  data_r     <= write_data;
                  is_write_r <= wr_en;
                  addr_r     <= {req_word_s, 1'b0};
                  we_n_r     <= ~wr_en;
                  dq_oe_r    <= wr_en;
                  dq_out_r   <= write_data[15:0];
               end
            end
            ST_LOW: begin
               if (phase_end_s) begin
                  state_r  <= ST_HIGH;
                  cnt_r    <= '0;
                  addr_r   <= {word_r, 1'b1};
                  dq_out_r <= data_r[31:16];
                  if (!is_write_r) begin
                     read_data_r[15:0] <= SRAM_DQ;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_HIGH: begin
               if (phase_end_s) begin
                  state_r  <= ST_DONE;
                  cnt_r    <= '0;
                  addr_r   <= '0;
                  we_n_r   <= 1'b1;
                  dq_oe_r  <= 1'b0;
                  dq_out_r <= 16'h0000;
                  if (!is_write_r) begin
                     read_data_r[31:16] <= SRAM_DQ;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Freeze decode: in IDLE a fresh request drops ready in the same cycle it appears.
   always_comb begin
      ready_s = 1'b0;
      case (state_r)
         ST_IDLE: ready_s = ~req_s;
         ST_DONE: ready_s = 1'b1;
         default: ready_s = 1'b0;
      endcase
   end

   assign ready     = ready_s;
   assign read_data = read_data_r;
   assign SRAM_ADDR = addr_r;
   assign SRAM_WE_N = we_n_r;
   assign SRAM_DQ   = dq_oe_r ? dq_out_r : 16'hzzzz;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
Bridges the pipeline MEM stage (32-bit word accesses) to the external 16-bit SRAM (18-bit half-word address, active-low strobes).
Each word access is split into two sequenced half-word accesses: low half first, then high half.
While an access is in progress, `ready` is low so the hazard/freeze logic stalls the pipeline.
Sits between the MEM stage and the Sram model, inside TOP_LEVEL.

Parameters:
- BASE_ADDR, 1024: byte address of data-memory word 0; subtracted from `address` before mapping.
- HALF_CYCLES, 2: cycles each half-word access is held on the SRAM bus (≥1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  MEM-stage store request.
- rd_en  in  1  MEM-stage load request.
- address  in  32  byte address, word-aligned.
- write_data  in  32  store data.
- read_data  out  32  load result, registered.
- ready  out  1  high = no access pending; low = freeze pipeline.
- SRAM_ADDR  out  18  half-word address.
- SRAM_DQ  inout  16  data bus; high-Z unless writing.
- SRAM_WE_N  out  1  write strobe, active low.
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  1 each  tied 0.

Behaviour:
- Clock and reset: one clock (`clk`); reset (`rst`) is synchronous and active-high.
- State machine: IDLE, LOW, HIGH, DONE. Phase counter `cnt` runs 0..HALF_CYCLES-1.
- Address mapping:
  - `word = (address - BASE_ADDR) >> 2`, truncated to 17 bits.
  - LOW phase drives SRAM_ADDR = {word, 1'b0}; HIGH phase drives SRAM_ADDR = {word, 1'b1}.
  - Outside LOW/HIGH, SRAM_ADDR = 0.
- IDLE:
  - ready = ~(wr_en | rd_en), combinational, so the freeze asserts in the same cycle the request appears.
  - On a request: capture address, write_data and op into registers (write wins if both enables are high), clear cnt, go to LOW.
- LOW / HIGH:
  - Held for exactly HALF_CYCLES cycles each; cnt increments per cycle and the phase advances when cnt == HALF_CYCLES-1.
  - Write: SRAM_DQ = captured data[15:0] (LOW) or data[31:16] (HIGH); SRAM_WE_N = 0 for every cycle of the phase.
  - Read: SRAM_WE_N = 1, DQ high-Z. SRAM_DQ is sampled into read_data[15:0] (LOW) or read_data[31:16] (HIGH) on the last cycle of the phase.
  - ready = 0 throughout.
- DONE:
  - Lasts one cycle; ready = 1, read_data is valid, then go to IDLE.
  - Pipeline advances on this edge, so a request seen in the following IDLE cycle is a new access.
- Latency: request at cycle 0 (IDLE), ready high at cycle 2*HALF_CYCLES+1 (5 at default).
- Requests deasserted mid-access are ignored; the captured access always completes.
- A write does not modify read_data. read_data holds its value until the next read completes.
- Reset (any state, including mid-access), values after the reset edge:
  - State IDLE, cnt = 0, read_data = 0.
  - SRAM_WE_N = 1, SRAM_DQ high-Z, SRAM_ADDR = 0.
  - ready = 1 if no request is present.
- No pipelining: one access in flight at a time.

Decomposition:
- Shared package: state encoding constants (IDLE/LOW/HIGH/DONE), BASE_ADDR default, SRAM width constants (ADDR 18, DQ 16).
- Single module, no sub-modules. The counter and the FSM are too small to split.

Test Plan:
- Store `address`=1024, `write_data`=0xDEADBEEF (wr_en) → ready low at cycles 0–4, high at cycle 5; Sram[0]=0xBEEF, Sram[1]=0xDEAD; WE_N low for 4 cycles total.
- Load `address`=1024 after that store → read_data=0xDEADBEEF at cycle 5; DQ never driven by the controller; SRAM_ADDR sequence 0,0,1,1.
- Store 0x12345678 at `address`=1028, then load from 1028 → Sram[2]=0x5678, Sram[3]=0x1234; read_data=0x12345678.
- wr_en=rd_en=1, `address`=1032, `write_data`=0xA5A5_5A5A → treated as write: Sram[4]=0x5A5A, Sram[5]=0xA5A5; read_data unchanged.
- rst pulsed at cycle 2 of a store of 0xCAFEF00D to 1036 → next cycle IDLE, WE_N=1, DQ high-Z; Sram[6] may hold 0xF00D, Sram[7] untouched.
- Back-to-back: load 1024 held through DONE, then new load 1028 → second access starts in the cycle after DONE; ready high for exactly one cycle between the two accesses.
